// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-4 stream demultiplexer: channel select encoding and decode helper.
package demux_pkg;

    localparam int NUM_CH = 4;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_A = 2'b00;
    localparam sel_t SEL_B = 2'b01;
    localparam sel_t SEL_C = 2'b10;
    localparam sel_t SEL_D = 2'b11;

    // One-hot channel decode; all four codes map to a channel, so there is no default branch.
    function automatic logic [NUM_CH-1:0] sel_decode(input sel_t s);
        logic [NUM_CH-1:0] oh;
        oh = '0;
        case (s)
            SEL_A: oh = 4'b0001;
            SEL_B: oh = 4'b0010;
            SEL_C: oh = 4'b0100;
            SEL_D: oh = 4'b1000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/demux_1to4_stream_if.sv
// Stream bundle for the demux: one tagged input stream plus four output channels.
// slave = demux side, master = producer/consumer side.
interface demux_1to4_stream_if
    import demux_pkg::*;
#(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0]        in_data;
    sel_t                    in_sel;
    logic                    in_valid;
    logic                    in_ready;
    logic [NUM_CH*WIDTH-1:0] out_data;
    logic [NUM_CH-1:0]       out_valid;
    logic [NUM_CH-1:0]       out_ready;

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );
endinterface

// File: rtl/demux_chan_fifo.sv
// Per-channel synchronous FIFO. Head data is exposed combinationally; while empty the
// output holds the last popped beat (zero after reset).
module demux_chan_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg, wr_ptr_next;
    logic [AW:0]      rd_ptr_reg, rd_ptr_next;
    logic [WIDTH-1:0] last_reg;
    logic             do_push, do_pop;

    // Extra MSB on each pointer distinguishes full from empty when the low bits match.
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (do_push) wr_ptr_next = wr_ptr_reg + (AW+1)'(1);
        if (do_pop)  rd_ptr_next = rd_ptr_reg + (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            last_reg   <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            if (do_pop) last_reg <= mem[rd_ptr_reg[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !reset) mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end

    assign head_data = empty ? last_reg : mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/demux_1to4_stream.sv
// 1-to-4 valid/ready stream demultiplexer with an independent FIFO per channel.
// Optional per-channel accepted-beat counters on port count when DEMUX_COUNT_EN is defined.
module demux_1to4_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    demux_1to4_stream_if.slave       bus
`ifdef DEMUX_COUNT_EN
    ,
    output logic [NUM_CH*8-1:0]      count
`endif
);
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] push_vec;
    logic [NUM_CH-1:0] pop_vec;
    logic [WIDTH-1:0]  head_data [NUM_CH];
    logic              sel_full;
    logic              in_ready_int;

    // in_ready depends only on the selected channel, so other channels never stall the producer.
    always_comb begin
        sel_full = 1'b0;
        case (bus.in_sel)
            SEL_A: sel_full = full[0];
            SEL_B: sel_full = full[1];
            SEL_C: sel_full = full[2];
            SEL_D: sel_full = full[3];
        endcase
        in_ready_int = !reset && !sel_full;
    end

    assign bus.in_ready = in_ready_int;
    assign push_vec     = (bus.in_valid && in_ready_int) ? sel_decode(bus.in_sel) : '0;
    assign pop_vec      = ~empty & bus.out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
            demux_chan_fifo #(
                .WIDTH (WIDTH),
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk       (clk),
                .reset     (reset),
                .push      (push_vec[gi]),
                .push_data (bus.in_data),
                .full      (full[gi]),
                .pop       (pop_vec[gi]),
                .empty     (empty[gi]),
                .head_data (head_data[gi])
            );
        end
    endgenerate

    always_comb begin
        bus.out_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            bus.out_data[k*WIDTH +: WIDTH] = head_data[k];
        end
    end

    assign bus.out_valid = ~empty;

`ifdef DEMUX_COUNT_EN
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_cnt
            logic [7:0] count_reg;
            always_ff @(posedge clk) begin
                if (reset)             count_reg <= '0;
                else if (push_vec[gi]) count_reg <= count_reg + 8'd1;
            end
            assign count[gi*8 +: 8] = count_reg;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_demux_1to4_stream.sv
// Randomized + directed bench for demux_1to4_stream with a queue-based channel model.
// Define DEMUX_COUNT_EN to also check the per-channel counters.
module tb_demux_1to4_stream;
    localparam int WIDTH = 4;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   mon_en = 0;

    demux_1to4_stream_if #(.WIDTH(WIDTH)) bus ();

`ifdef DEMUX_COUNT_EN
    logic [31:0] count;
    demux_1to4_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .bus(bus), .count(count));
`else
    demux_1to4_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .bus(bus));
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: each channel is a bounded queue of accepted beats, plus the last popped value.
    logic [WIDTH-1:0] mq [4][$];
    logic [WIDTH-1:0] last_pop [4];
    logic [7:0]       cnt [4];
    logic [3:0]       exp_v;
    logic             exp_rdy;

    initial begin
        for (int k = 0; k < 4; k++) begin
            last_pop[k] = '0;
            cnt[k] = '0;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < 4; k++) exp_v[k] = (mq[k].size() != 0);
            chk("out_valid", 32'(bus.out_valid), 32'(exp_v));
            for (int k = 0; k < 4; k++)
                chk($sformatf("out_data[%0d]", k), 32'(bus.out_data[k*WIDTH +: WIDTH]),
                    32'(exp_v[k] ? mq[k][0] : last_pop[k]));
            exp_rdy = !reset && (mq[bus.in_sel].size() < DEPTH);
            chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
`ifdef DEMUX_COUNT_EN
            chk("count", count, {cnt[3], cnt[2], cnt[1], cnt[0]});
`endif
            if (reset) begin
                for (int k = 0; k < 4; k++) begin
                    mq[k].delete();
                    last_pop[k] = '0;
                    cnt[k] = '0;
                end
            end else begin
                for (int k = 0; k < 4; k++)
                    if (exp_v[k] && bus.out_ready[k]) last_pop[k] = mq[k].pop_front();
                if (bus.in_valid && exp_rdy) begin
                    mq[bus.in_sel].push_back(bus.in_data);
                    cnt[bus.in_sel] = cnt[bus.in_sel] + 8'd1;
                end
            end
        end
    end

    task automatic send(input logic [1:0] s, input logic [WIDTH-1:0] d);
        int n = 0;
        bus.in_sel   = s;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 200);
        checks++;
        if (!bus.in_ready) begin
            errors++;
            $display("FAIL send_timeout: in_ready=%0b required 1 sel=%0d", bus.in_ready, s);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    int  t0;
    bit  hs;

    initial begin
        reset = 1'b1;
        bus.in_data = '0; bus.in_sel = '0; bus.in_valid = 1'b0; bus.out_ready = 4'b0000;
        @(posedge clk); #1 mon_en = 1;
        @(posedge clk); #1 reset = 1'b0;

        // 1: one beat per channel, all consumers ready
        bus.out_ready = 4'b1111;
        for (int k = 0; k < 4; k++) send(2'(k), 4'(k + 1));
        repeat (3) @(posedge clk); #1;

        // 2: three beats to c with consumers stalled; release c after a few cycles
        bus.out_ready = 4'b0000;
        fork
            begin
                send(2'b10, 4'hA); send(2'b10, 4'hB); send(2'b10, 4'hC);
            end
            begin
                repeat (5) @(posedge clk); #1 bus.out_ready[2] = 1'b1;
            end
        join
        repeat (3) @(posedge clk); #1;

        // 3: c full, a still accepts in a single cycle
        bus.out_ready = 4'b0000;
        send(2'b10, 4'h5); send(2'b10, 4'h6);
        t0 = cyc;
        send(2'b00, 4'h7);
        chk("no_hol_latency", 32'(cyc - t0), 32'd1);
        bus.out_ready = 4'b1111;
        repeat (3) @(posedge clk); #1;

        // 4: sustained stream to b at full rate
        t0 = cyc;
        for (int i = 0; i < 16; i++) send(2'b01, 4'(i));
        chk("throughput_cycles", 32'(cyc - t0), 32'd16);
        repeat (3) @(posedge clk); #1;

        // 5: reset with a and d occupied; nothing stale may emerge afterwards
        bus.out_ready = 4'b0000;
        send(2'b00, 4'h8); send(2'b00, 4'h9); send(2'b11, 4'hE);
        do_reset();
        bus.out_ready = 4'b1111;
        repeat (4) @(posedge clk); #1;

`ifdef DEMUX_COUNT_EN
        // 6: counter wrap on channel d
        do_reset();
        for (int i = 0; i < 257; i++) send(2'b11, 4'(i));
        @(negedge clk);
        chk("count_d_wrap", 32'(count[31:24]), 32'h01);
        @(posedge clk); #1;
`endif

        // Random traffic honouring the producer hold rule
        hs = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            hs = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (!bus.in_valid || hs) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.in_sel   = 2'($urandom_range(0, 3));
                bus.in_data  = 4'($urandom_range(0, 15));
            end
            bus.out_ready = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 299) == 0 && !bus.in_valid) reset = 1'b1;
            else reset = 1'b0;
        end
        reset = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 4'b1111;
        repeat (6) @(posedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
